// File: rtl/pipe_pkg.sv
// Shared tag constants, forwarding encodings and hazard FSM state for the
// five-stage core's hazard/forwarding controller.
package pipe_pkg;

  localparam int TAG_W = 4;

  localparam logic [TAG_W-1:0] TAG_R0   = 4'd0;
  localparam logic [TAG_W-1:0] TAG_R1   = 4'd1;
  localparam logic [TAG_W-1:0] TAG_R2   = 4'd2;
  localparam logic [TAG_W-1:0] TAG_R3   = 4'd3;
  localparam logic [TAG_W-1:0] TAG_R4   = 4'd4;
  localparam logic [TAG_W-1:0] TAG_R5   = 4'd5;
  localparam logic [TAG_W-1:0] TAG_R6   = 4'd6;
  localparam logic [TAG_W-1:0] TAG_R7   = 4'd7;
  localparam logic [TAG_W-1:0] TAG_SP   = 4'd8;
  localparam logic [TAG_W-1:0] TAG_IH   = 4'd9;
  localparam logic [TAG_W-1:0] TAG_T    = 4'd10;
  localparam logic [TAG_W-1:0] TAG_RA   = 4'd11;
  localparam logic [TAG_W-1:0] TAG_NONE = 4'hF;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef enum logic {RUN, LU_STALL} hz_state_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             is_load;
  } slot_t;

endpackage

// File: rtl/fwd_select.sv
// Operand forwarding comparator: picks the newest in-flight producer of one
// source tag. An EX-stage load is skipped because its data is not ready yet.
module fwd_select
  import pipe_pkg::*;
(
  input  logic [TAG_W-1:0] src,
  input  logic [TAG_W-1:0] ex_tag,
  input  logic             ex_is_load,
  input  logic [TAG_W-1:0] mem_tag,
  input  logic [TAG_W-1:0] wb_tag,
  output logic [1:0]       sel
);

  always_comb begin
    // NOTE: default first so every path assigns sel and no latch is inferred.
    sel = FWD_REG;
    if (src != TAG_NONE) begin
      if (src == ex_tag && !ex_is_load) sel = FWD_EX;
      else if (src == mem_tag)          sel = FWD_MEM;
      else if (src == wb_tag)           sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall/flush controller for the IF/ID/EX/MEM/WB core.
// Define HAZARD_PERF_EN to add stall/flush cycle counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [TAG_W-1:0] id_src_x,
  input  logic [TAG_W-1:0] id_src_y,
  input  logic [TAG_W-1:0] id_dst,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_struct_conflict,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic [1:0]       fwd_x_sel,
  output logic [1:0]       fwd_y_sel
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]      perf_stall_cnt,
  output logic [15:0]      perf_flush_cnt
`endif
);

  slot_t            ex_q;
  slot_t            mem_q;
  logic [TAG_W-1:0] wb_tag_q;
  hz_state_e        state_q;

  logic       load_use;
  logic [1:0] sel_x;
  logic [1:0] sel_y;

  // Only one stall per load: after LU_STALL the load sits in MEM and forwards.
  assign load_use = (state_q == RUN) && ex_q.is_load && (ex_q.tag != TAG_NONE) &&
                    ((ex_q.tag == id_src_x) || (ex_q.tag == id_src_y));

  fwd_select u_fwd_x (
    .src        (id_src_x),
    .ex_tag     (ex_q.tag),
    .ex_is_load (ex_q.is_load),
    .mem_tag    (mem_q.tag),
    .wb_tag     (wb_tag_q),
    .sel        (sel_x)
  );

  fwd_select u_fwd_y (
    .src        (id_src_y),
    .ex_tag     (ex_q.tag),
    .ex_is_load (ex_q.is_load),
    .mem_tag    (mem_q.tag),
    .wb_tag     (wb_tag_q),
    .sel        (sel_y)
  );

  // Priority: taken branch, then load-use, then the shared-SRAM conflict.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    flush_id  = 1'b0;
    bubble_ex = 1'b0;
    fwd_x_sel = FWD_REG;
    fwd_y_sel = FWD_REG;
    if (rst) begin
      fwd_x_sel = sel_x;
      fwd_y_sel = sel_y;
      if (ex_branch_taken) begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (load_use) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (mem_struct_conflict) begin
        stall_if  = 1'b1;
        flush_id  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: only control state lives here, so every register takes the async reset.
    if (!rst) begin
      ex_q     <= '{tag: TAG_NONE, is_load: 1'b0};
      mem_q    <= '{tag: TAG_NONE, is_load: 1'b0};
      wb_tag_q <= TAG_NONE;
      state_q  <= RUN;
    end else begin
      // NOTE: non-blocking so each slot samples its predecessor's old value.
      wb_tag_q <= mem_q.tag;
      mem_q    <= ex_q;
      if (bubble_ex || !id_valid) ex_q <= '{tag: TAG_NONE, is_load: 1'b0};
      else                        ex_q <= '{tag: id_dst, is_load: id_is_load};
      state_q <= (!ex_branch_taken && load_use) ? LU_STALL : RUN;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= 16'd0;
      perf_flush_cnt <= 16'd0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + {15'd0, stall_id};
      perf_flush_cnt <= perf_flush_cnt + {15'd0, flush_id};
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios followed
// by random traffic, all compared against a pipeline-array reference model.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;
  import pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_src_x, id_src_y, id_dst;
  logic       id_is_load, ex_branch_taken, mem_struct_conflict;
  logic       stall_if, stall_id, flush_id, bubble_ex;
  logic [1:0] fwd_x_sel, fwd_y_sel;
`ifdef HAZARD_PERF_EN
  logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif

  pipe_hazard_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .id_valid            (id_valid),
    .id_src_x            (id_src_x),
    .id_src_y            (id_src_y),
    .id_dst              (id_dst),
    .id_is_load          (id_is_load),
    .ex_branch_taken     (ex_branch_taken),
    .mem_struct_conflict (mem_struct_conflict),
    .stall_if            (stall_if),
    .stall_id            (stall_id),
    .flush_id            (flush_id),
    .bubble_ex           (bubble_ex),
    .fwd_x_sel           (fwd_x_sel),
    .fwd_y_sel           (fwd_y_sel)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt      (perf_stall_cnt),
    .perf_flush_cnt      (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference pipeline: index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    logic [3:0] tag;
    bit         load;
  } mslot_t;

  mslot_t pipe_m[3];
  bit     prev_lu;
  int     stall_cycles;
  int     flush_cycles;

  function automatic logic [1:0] model_fwd(logic [3:0] src);
    if (src == TAG_NONE) return 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (pipe_m[i].tag == src && !(i == 0 && pipe_m[0].load)) return 2'(i + 1);
    end
    return 2'd0;
  endfunction

  task automatic check(input string name, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      pipe_m[i].tag  = TAG_NONE;
      pipe_m[i].load = 1'b0;
    end
    prev_lu      = 1'b0;
    stall_cycles = 0;
    flush_cycles = 0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_stall_if"},  {15'd0, stall_if},  16'd0);
    check({name, "_stall_id"},  {15'd0, stall_id},  16'd0);
    check({name, "_flush_id"},  {15'd0, flush_id},  16'd0);
    check({name, "_bubble_ex"}, {15'd0, bubble_ex}, 16'd0);
    check({name, "_fwd_x"},     {14'd0, fwd_x_sel}, 16'd0);
    check({name, "_fwd_y"},     {14'd0, fwd_y_sel}, 16'd0);
  endtask

  // One clock: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic apply(input string name, input bit v, input logic [3:0] sx,
                       input logic [3:0] sy, input logic [3:0] dst, input bit ld,
                       input bit br, input bit sc);
    bit lu, e_si, e_sid, e_fl, e_bx;
    logic [1:0] e_fx, e_fy;
    id_valid = v; id_src_x = sx; id_src_y = sy; id_dst = dst;
    id_is_load = ld; ex_branch_taken = br; mem_struct_conflict = sc;
    lu = pipe_m[0].load && pipe_m[0].tag != TAG_NONE &&
         (pipe_m[0].tag == sx || pipe_m[0].tag == sy) && !prev_lu;
    e_si = 0; e_sid = 0; e_fl = 0; e_bx = 0;
    if (br) begin
      e_fl = 1; e_bx = 1; lu = 0;
    end else if (lu) begin
      e_si = 1; e_sid = 1; e_bx = 1;
    end else if (sc) begin
      e_si = 1; e_fl = 1;
    end
    e_fx = model_fwd(sx);
    e_fy = model_fwd(sy);
    @(negedge clk);
    check({name, "_stall_if"},  {15'd0, stall_if},  {15'd0, e_si});
    check({name, "_stall_id"},  {15'd0, stall_id},  {15'd0, e_sid});
    check({name, "_flush_id"},  {15'd0, flush_id},  {15'd0, e_fl});
    check({name, "_bubble_ex"}, {15'd0, bubble_ex}, {15'd0, e_bx});
    check({name, "_fwd_x"},     {14'd0, fwd_x_sel}, {14'd0, e_fx});
    check({name, "_fwd_y"},     {14'd0, fwd_y_sel}, {14'd0, e_fy});
    @(posedge clk);
    pipe_m[2] = pipe_m[1];
    pipe_m[1] = pipe_m[0];
    pipe_m[0].tag  = (e_bx || !v) ? TAG_NONE : dst;
    pipe_m[0].load = !e_bx && v && ld;
    prev_lu = lu;
    stall_cycles += int'(e_sid);
    flush_cycles += int'(e_fl);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] tagset [5];
    tagset = '{TAG_R1, TAG_R2, TAG_R3, TAG_T, TAG_NONE};
    model_reset();

    // Reset held: outputs forced to 0 even with branch/conflict driven.
    rst = 1'b0;
    id_valid = 1; id_src_x = TAG_R1; id_src_y = TAG_R2; id_dst = TAG_R1;
    id_is_load = 1; ex_branch_taken = 1; mem_struct_conflict = 1;
    #1;
    check_all_zero("in_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Forwarding ladder EX -> MEM -> WB -> regfile.
    apply("addu_r1", 1, TAG_NONE, TAG_NONE, TAG_R1, 0, 0, 0);
    apply("fwd_ex",  1, TAG_R1, TAG_NONE, TAG_NONE, 0, 0, 0);
    apply("fwd_mem", 1, TAG_R1, TAG_NONE, TAG_NONE, 0, 0, 0);
    apply("fwd_wb",  1, TAG_R1, TAG_NONE, TAG_NONE, 0, 0, 0);
    apply("fwd_reg", 1, TAG_R1, TAG_NONE, TAG_NONE, 0, 0, 0);

    // Load-use on opY: one stall cycle, then MEM forward.
    apply("lw_r2",     1, TAG_NONE, TAG_NONE, TAG_R2, 1, 0, 0);
    apply("lu_stall",  1, TAG_NONE, TAG_R2, TAG_NONE, 0, 0, 0);
    apply("lu_after",  1, TAG_NONE, TAG_R2, TAG_NONE, 0, 0, 0);

    // T register forwarded from cmp.
    apply("cmp_t",   1, TAG_R3, TAG_R4, TAG_T, 0, 0, 0);
    apply("bteqz_t", 1, TAG_T, TAG_NONE, TAG_NONE, 0, 0, 0);

    // Branch overrides load-use; FSM stays RUN so next load-use still stalls.
    apply("lw_r3",     1, TAG_NONE, TAG_NONE, TAG_R3, 1, 0, 0);
    apply("br_vs_lu",  1, TAG_R3, TAG_NONE, TAG_NONE, 0, 1, 0);
    apply("lw_r4",     1, TAG_NONE, TAG_NONE, TAG_R4, 1, 0, 0);
    apply("lu_post_br",1, TAG_R4, TAG_NONE, TAG_NONE, 0, 0, 0);
    apply("settle0",   1, TAG_R4, TAG_NONE, TAG_NONE, 0, 0, 0);

    // Structural conflict alone, then combined with load-use.
    apply("sc_alone",  0, TAG_NONE, TAG_NONE, TAG_NONE, 0, 0, 1);
    apply("lw_r5",     1, TAG_NONE, TAG_NONE, TAG_R5, 1, 0, 0);
    apply("sc_and_lu", 1, TAG_R5, TAG_NONE, TAG_NONE, 0, 0, 1);
    apply("sc_next",   1, TAG_R5, TAG_NONE, TAG_NONE, 0, 0, 1);

    // Reset pulsed during LU_STALL.
    apply("lw_r6",    1, TAG_NONE, TAG_NONE, TAG_R6, 1, 0, 0);
    apply("lu_r6",    1, TAG_R6, TAG_R6, TAG_NONE, 0, 0, 0);
    ex_branch_taken = 1; mem_struct_conflict = 1;
    rst = 1'b0;
    #1;
    check_all_zero("rst_mid_stall");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    apply("post_rst_r6", 1, TAG_R6, TAG_R6, TAG_NONE, 0, 0, 0);
    apply("post_rst_lu", 1, TAG_NONE, TAG_NONE, TAG_R2, 1, 0, 0);
    apply("post_rst_st", 1, TAG_R2, TAG_NONE, TAG_NONE, 0, 0, 0);

    // Random traffic over a small tag set to provoke frequent matches.
    for (int n = 0; n < 400; n++) begin
      apply("rand",
            ($urandom_range(0, 9) != 0),
            tagset[$urandom_range(0, 4)],
            tagset[$urandom_range(0, 4)],
            tagset[$urandom_range(0, 4)],
            ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 19) < 3));
    end

`ifdef HAZARD_PERF_EN
    @(negedge clk);
    check("perf_stall_cnt", perf_stall_cnt, stall_cycles[15:0]);
    check("perf_flush_cnt", perf_flush_cnt, flush_cycles[15:0]);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
